replica_sequencer: RTL and testbench
====================================

# replica_sequencer

Top-level iteration controller for the replica array. It sits directly upstream of every replica instance and broadcasts the per-cycle commands that step all replicas in lock-step through one annealing iteration. The iteration order is: random draw, delta-distance evaluation, Metropolis decision, ordering update, and (periodically) an even/odd replica exchange. It also owns the ordering read-bank toggle (`rbank`) and the iteration count.

## Interface
Parameters:
- `DIST_LAT`, 8: wait cycles after a distance issue
- `METRO_LAT`, 4: wait cycles after a Metropolis issue
- `APPLY_LAT`, 4: wait cycles after an exchange (ordering) issue
- `EXCH_INTERVAL`, 16: iterations between replica exchanges; must be ≥1

Ports:
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-low
- `start` in 1: begin a run; sampled only in IDLE
- `seed_load` in 1: qualifies `start`; issue `random_init` before the first iteration
- `stop` in 1: finish the current iteration, then end the run
- `opt_mode` in 2: 0 = alternate opt types, 1 = or-opt only, 2 = 2-opt only, 3 = reserved (treated as 0)
- `iter_num` in 32: number of iterations to run
- `busy` out 1: run in progress
- `done` out 1: one-cycle pulse at run end
- `iter_count` out 32: completed iterations
- `random_init` out 1, `random_run` out 1: to the random units
- `opt_command` out `opt_command_t`
- `c_distance` out `distance_command_t`
- `c_metropolis` out `exchange_command_t`
- `c_exchange` out `exchange_command_t`
- `rbank` out 1: ordering read bank

## Operation
- FSM states: IDLE, INIT, RAND, DIST, METRO, APPLY, XMETRO, XAPPLY, FIN.
- **IDLE to INIT or RAND:** `start`=1 with `iter_num`≠0 moves to INIT if `seed_load`=1, otherwise to RAND. On entry, clear `iter_count` and exchange parity, and set `busy`.
- **`iter_num`=0:** `start` goes straight to FIN.
- **INIT:** `random_init`=1 for one cycle, then RAND.
- **RAND:** `random_run`=1 for one cycle. `opt_command` is set here and held through DIST, METRO and APPLY:
  - mode 1 gives OPT_OR.
  - mode 2 gives OPT_TWO.
  - mode 0 gives OPT_OR on even `iter_count` and OPT_TWO on odd `iter_count`.
- **Phased states (DIST, METRO, APPLY, XMETRO, XAPPLY):** each has one issue cycle with the command non-NOP, followed by a wait of the phase's `*_LAT` cycles with all commands NOP. A single 8-bit down-counter is shared by all phases.
  - DIST issues `c_distance`=DIS_RUN.
  - METRO issues `c_metropolis`=EXC_OPT.
  - APPLY issues `c_exchange`=EXC_OPT.
- **End of APPLY:** `rbank` toggles and `iter_count` increments.
  - If the new count is a multiple of `EXCH_INTERVAL`, go to XMETRO.
  - Otherwise, go to FIN if the count equals `iter_num` or `stop` is latched, else back to RAND.
- **XMETRO, XAPPLY:** issue EXC_EVEN or EXC_ODD per exchange parity, on `c_metropolis` and then `c_exchange`. Parity toggles at the end of XAPPLY, and the first exchange of a run is EVEN. The next state is then decided as for the end of APPLY.
- **FIN:** `done`=1 for one cycle and `busy`=0 in the same cycle, then IDLE.
- **`stop`:** latched whenever it is seen high while busy. It is honoured only at iteration end, and any exchange due at that boundary is still performed. The latch clears in FIN.
- **Reset values** (all outputs, asynchronous): all commands NOP/NONE (encoding 0), `rbank`=0, `busy`=0, `done`=0, `iter_count`=0, `random_*`=0.
- **Reset mid-run:** aborts immediately to IDLE with no `done` pulse.
- **`start` outside IDLE:** ignored.

## Timing
- All outputs are registered, and each command is non-NOP for exactly one cycle.
- The first RAND issue occurs 1 cycle after `start`, or 2 cycles when `seed_load` is set.
- **Iteration length:** 3 + 1 + `DIST_LAT` + `METRO_LAT` + `APPLY_LAT` cycles, which is 20 with defaults.
  - An exchange iteration adds 2 + `METRO_LAT` + `APPLY_LAT`, which is 10 with defaults.
- `rbank` and `iter_count` update on the same edge that leaves the APPLY wait.
- `done` follows the last wait cycle by exactly one cycle.
- **`stop` and run end in the same cycle:** completion is taken, with a single `done`.
- **`iter_count` wrap:** cannot occur, because it is bounded by `iter_num`.

## Structure
- `opt_command_t` {OPT_NONE, OPT_OR, OPT_TWO}, `distance_command_t` {DIS_NOP, DIS_RUN}, `exchange_command_t` {EXC_NOP, EXC_OPT, EXC_EVEN, EXC_ODD} and the state enum all belong in `replica_pkg`.
- Optional sub-module `phase_timer`: loadable 8-bit down-counter with a zero flag.

## Test plan
- **Plain run:** `iter_num`=3, defaults → 3 DIS_RUN pulses 20 cycles apart; `rbank` sequence 1,0,1; `done` at cycle 61 after `start`; `iter_count`=3.
- **Seeded start:** `seed_load`=1 → `random_init` at cycle 1, `random_run` at cycle 2.
- **Exchanges:** `EXCH_INTERVAL`=2, `iter_num`=4 → EXC_EVEN after iteration 2, EXC_ODD after iteration 4, each iteration 30 cycles.
- **`opt_mode` 0:** `opt_command` alternates OPT_OR, OPT_TWO, OPT_OR.
- **Early stop:** `stop` pulsed during the DIST phase of iteration 2 of 10 → `done` after iteration 2, `iter_count`=2.
- **Mid-run reset:** reset asserted in METRO → all outputs 0 asynchronously, no `done`. A subsequent `start` runs cleanly.

Source files
------------

// File: rtl/replica_pkg.sv
// Shared types for the replica array iteration controller: command encodings
// broadcast to every replica, the sequencer state encoding and small helpers.
package replica_pkg;

    // Optimisation move selected for the current iteration.
    typedef enum logic [1:0] {
        OPT_NONE = 2'd0,
        OPT_OR   = 2'd1,
        OPT_TWO  = 2'd2
    } opt_command_t;

    // Delta-distance evaluation command.
    typedef enum logic [0:0] {
        DIS_NOP = 1'b0,
        DIS_RUN = 1'b1
    } distance_command_t;

    // Metropolis / ordering-update command; EVEN/ODD select exchange pairing.
    typedef enum logic [1:0] {
        EXC_NOP  = 2'd0,
        EXC_OPT  = 2'd1,
        EXC_EVEN = 2'd2,
        EXC_ODD  = 2'd3
    } exchange_command_t;

    // Sequencer states.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INIT   = 4'd1,
        ST_RAND   = 4'd2,
        ST_DIST   = 4'd3,
        ST_METRO  = 4'd4,
        ST_APPLY  = 4'd5,
        ST_XMETRO = 4'd6,
        ST_XAPPLY = 4'd7,
        ST_FIN    = 4'd8
    } seq_state_t;

    localparam logic [1:0] MODE_OR  = 2'd1;
    localparam logic [1:0] MODE_TWO = 2'd2;

    // Mode 0 and the reserved mode 3 alternate: OR on even counts, 2-opt on odd.
    function automatic opt_command_t opt_select(input logic [1:0] mode,
                                                input logic count_odd);
        opt_command_t sel;
        case (mode)
            MODE_OR:  sel = OPT_OR;
            MODE_TWO: sel = OPT_TWO;
            default:  sel = count_odd ? OPT_TWO : OPT_OR;
        endcase
        return sel;
    endfunction

    // States that consist of one issue cycle followed by a latency wait.
    function automatic logic is_phase(input seq_state_t s);
        logic ph;
        case (s)
            ST_DIST, ST_METRO, ST_APPLY, ST_XMETRO, ST_XAPPLY: ph = 1'b1;
            default:                                           ph = 1'b0;
        endcase
        return ph;
    endfunction

    // Exchange pairing for the current parity: the first exchange of a run is EVEN.
    function automatic exchange_command_t parity_exchange(input logic odd);
        return odd ? EXC_ODD : EXC_EVEN;
    endfunction

endpackage

// File: rtl/replica_sequencer_phase_timer.sv
// Loadable 8-bit down-counter shared by all phased states. The counter holds
// at zero; the zero flag tells the sequencer the current wait is over.
module phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt_r;

    // Count down from the loaded latency and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (srst) begin
            cnt_r <= 8'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == 8'd0);

endmodule

// File: rtl/replica_sequencer.sv
// Iteration controller for the replica array. Steps every replica in lock-step
// through random draw, distance evaluation, Metropolis decision and ordering
// update, with a periodic even/odd replica exchange. All outputs are registered
// and derived from the next state, so each command appears in the cycle the
// corresponding state is occupied.
module replica_sequencer
    import replica_pkg::*;
#(
    parameter int unsigned DIST_LAT      = 8,
    parameter int unsigned METRO_LAT     = 4,
    parameter int unsigned APPLY_LAT     = 4,
    parameter int unsigned EXCH_INTERVAL = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              seed_load,
    input  logic              stop,
    input  logic [1:0]        opt_mode,
    input  logic [31:0]       iter_num,
    output logic              busy,
    output logic              done,
    output logic [31:0]       iter_count,
    output logic              random_init,
    output logic              random_run,
    output opt_command_t      opt_command,
    output distance_command_t c_distance,
    output exchange_command_t c_metropolis,
    output exchange_command_t c_exchange,
    output logic              rbank
);

    localparam logic [7:0]  DIST_LAT_C  = 8'(DIST_LAT);
    localparam logic [7:0]  METRO_LAT_C = 8'(METRO_LAT);
    localparam logic [7:0]  APPLY_LAT_C = 8'(APPLY_LAT);
    localparam logic [31:0] EXCH_INT_C  = 32'(EXCH_INTERVAL);

    seq_state_t        state_r, state_next_s;
    logic [31:0]       iter_count_r, iter_count_next_s;
    logic [31:0]       iter_num_r, iter_num_next_s;
    logic [31:0]       xcnt_r, xcnt_next_s;
    logic              parity_r, parity_next_s;
    logic              stop_r, stop_next_s;
    logic              rbank_r, rbank_next_s;
    logic              stop_seen_s;
    logic              run_state_s;
    logic              entering_s;

    logic              timer_load_s;
    logic [7:0]        timer_val_s;
    logic              timer_zero_s;
    logic              timer_srst_s;

    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;
    logic              random_init_r, random_init_next_s;
    logic              random_run_r, random_run_next_s;
    opt_command_t      opt_command_r, opt_command_next_s;
    distance_command_t c_distance_r, c_distance_next_s;
    exchange_command_t c_metropolis_r, c_metropolis_next_s;
    exchange_command_t c_exchange_r, c_exchange_next_s;

    // The wait counter is idle-cleared so every run starts from a known value.
    assign timer_srst_s = (state_r == ST_IDLE);

    phase_timer u_phase_timer (
        .clk      (clk),
        .rst_n    (reset),
        .srst     (timer_srst_s),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .zero     (timer_zero_s)
    );

    // Next-state, iteration bookkeeping and stop latching.
    always_comb begin
        state_next_s      = state_r;
        iter_count_next_s = iter_count_r;
        iter_num_next_s   = iter_num_r;
        xcnt_next_s       = xcnt_r;
        parity_next_s     = parity_r;
        rbank_next_s      = rbank_r;
        run_state_s       = (state_r != ST_IDLE) && (state_r != ST_FIN);
        stop_seen_s       = stop_r | stop;

        if (stop && run_state_s) begin
            stop_next_s = 1'b1;
        end else begin
            stop_next_s = stop_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    iter_count_next_s = 32'd0;
                    iter_num_next_s   = iter_num;
                    xcnt_next_s       = 32'd0;
                    parity_next_s     = 1'b0;
                    stop_next_s       = 1'b0;
                    if (iter_num == 32'd0) begin
                        state_next_s = ST_FIN;
                    end else if (seed_load) begin
                        state_next_s = ST_INIT;
                    end else begin
                        state_next_s = ST_RAND;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_INIT: state_next_s = ST_RAND;
            ST_RAND: state_next_s = ST_DIST;
            ST_DIST: begin
                if (timer_zero_s) begin
                    state_next_s = ST_METRO;
                end else begin
                    state_next_s = ST_DIST;
                end
            end
            ST_METRO: begin
                if (timer_zero_s) begin
                    state_next_s = ST_APPLY;
                end else begin
                    state_next_s = ST_METRO;
                end
            end
            ST_APPLY: begin
                if (timer_zero_s) begin
                    rbank_next_s      = ~rbank_r;
                    iter_count_next_s = iter_count_r + 32'd1;
                    if ((xcnt_r + 32'd1) == EXCH_INT_C) begin
                        xcnt_next_s  = 32'd0;
                        state_next_s = ST_XMETRO;
                    end else begin
                        xcnt_next_s = xcnt_r + 32'd1;
                        if (((iter_count_r + 32'd1) == iter_num_r) || stop_seen_s) begin
                            state_next_s = ST_FIN;
                        end else begin
                            state_next_s = ST_RAND;
                        end
                    end
                end else begin
                    state_next_s = ST_APPLY;
                end
            end
            ST_XMETRO: begin
                if (timer_zero_s) begin
                    state_next_s = ST_XAPPLY;
                end else begin
                    state_next_s = ST_XMETRO;
                end
            end
            ST_XAPPLY: begin
                if (timer_zero_s) begin
                    parity_next_s = ~parity_r;
                    if ((iter_count_r == iter_num_r) || stop_seen_s) begin
                        state_next_s = ST_FIN;
                    end else begin
                        state_next_s = ST_RAND;
                    end
                end else begin
                    state_next_s = ST_XAPPLY;
                end
            end
            ST_FIN: begin
                stop_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Load the shared wait counter with the latency of the phase being entered.
    always_comb begin
        entering_s   = (state_next_s != state_r);
        timer_load_s = 1'b0;
        timer_val_s  = 8'd0;
        if (entering_s && is_phase(state_next_s)) begin
            timer_load_s = 1'b1;
            case (state_next_s)
                ST_DIST:              timer_val_s = DIST_LAT_C;
                ST_METRO, ST_XMETRO:  timer_val_s = METRO_LAT_C;
                ST_APPLY, ST_XAPPLY:  timer_val_s = APPLY_LAT_C;
                default:              timer_val_s = 8'd0;
            endcase
        end else begin
            timer_load_s = 1'b0;
            timer_val_s  = 8'd0;
        end
    end

    // Output values for the state about to be occupied; commands only on entry.
    always_comb begin
        busy_next_s         = (state_next_s != ST_IDLE) && (state_next_s != ST_FIN);
        done_next_s         = (state_next_s == ST_FIN);
        random_init_next_s  = (state_next_s == ST_INIT);
        random_run_next_s   = (state_next_s == ST_RAND);
        c_distance_next_s   = DIS_NOP;
        c_metropolis_next_s = EXC_NOP;
        c_exchange_next_s   = EXC_NOP;
        opt_command_next_s  = OPT_NONE;

        if (entering_s) begin
            case (state_next_s)
                ST_DIST:   c_distance_next_s   = DIS_RUN;
                ST_METRO:  c_metropolis_next_s = EXC_OPT;
                ST_APPLY:  c_exchange_next_s   = EXC_OPT;
                ST_XMETRO: c_metropolis_next_s = parity_exchange(parity_r);
                ST_XAPPLY: c_exchange_next_s   = parity_exchange(parity_r);
                default:   c_distance_next_s   = DIS_NOP;
            endcase
        end else begin
            c_distance_next_s = DIS_NOP;
        end

        // The move type is chosen from the count the new iteration starts with.
        case (state_next_s)
            ST_RAND:                     opt_command_next_s = opt_select(opt_mode, iter_count_next_s[0]);
            ST_DIST, ST_METRO, ST_APPLY: opt_command_next_s = opt_command_r;
            default:                     opt_command_next_s = OPT_NONE;
        endcase
    end

    // Sequencer state and per-run bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            iter_count_r <= 32'd0;
            iter_num_r   <= 32'd0;
            xcnt_r       <= 32'd0;
            parity_r     <= 1'b0;
            stop_r       <= 1'b0;
            rbank_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            iter_count_r <= iter_count_next_s;
            iter_num_r   <= iter_num_next_s;
            xcnt_r       <= xcnt_next_s;
            parity_r     <= parity_next_s;
            stop_r       <= stop_next_s;
            rbank_r      <= rbank_next_s;
        end
    end

    // Registered command and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            random_init_r  <= 1'b0;
            random_run_r   <= 1'b0;
            opt_command_r  <= OPT_NONE;
            c_distance_r   <= DIS_NOP;
            c_metropolis_r <= EXC_NOP;
            c_exchange_r   <= EXC_NOP;
        end else begin
            busy_r         <= busy_next_s;
            done_r         <= done_next_s;
            random_init_r  <= random_init_next_s;
            random_run_r   <= random_run_next_s;
            opt_command_r  <= opt_command_next_s;
            c_distance_r   <= c_distance_next_s;
            c_metropolis_r <= c_metropolis_next_s;
            c_exchange_r   <= c_exchange_next_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign iter_count   = iter_count_r;
    assign random_init  = random_init_r;
    assign random_run   = random_run_r;
    assign opt_command  = opt_command_r;
    assign c_distance   = c_distance_r;
    assign c_metropolis = c_metropolis_r;
    assign c_exchange   = c_exchange_r;
    assign rbank        = rbank_r;

endmodule

// File: tb/tb_replica_sequencer.sv
// Directed bench for replica_sequencer. Instance A uses default parameters,
// instance B uses an exchange interval of 2; both share the same stimulus.
// Cycle k of a run is the k-th clock period after the edge that samples start.
module tb_replica_sequencer;
    import replica_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        seed_load;
    logic        stop;
    logic [1:0]  opt_mode;
    logic [31:0] iter_num;

    logic              busy_a, done_a, rinit_a, rrun_a, rbank_a;
    logic [31:0]       icnt_a;
    opt_command_t      opt_a;
    distance_command_t dist_a;
    exchange_command_t met_a, exc_a;

    logic              busy_b, done_b, rinit_b, rrun_b, rbank_b;
    logic [31:0]       icnt_b;
    opt_command_t      opt_b;
    distance_command_t dist_b;
    exchange_command_t met_b, exc_b;

    int chk_cnt;
    int pass_cnt;

    logic [1:0]  log_opt_a   [0:255];
    logic        log_dist_a  [0:255];
    logic [1:0]  log_met_a   [0:255];
    logic        log_rbank_a [0:255];
    logic        log_busy_a  [0:255];
    logic        log_done_a  [0:255];
    logic        log_rinit_a [0:255];
    logic        log_rrun_a  [0:255];
    logic [31:0] log_icnt_a  [0:255];
    logic [1:0]  log_met_b   [0:255];
    logic [1:0]  log_exc_b   [0:255];
    logic        log_done_b  [0:255];
    logic [31:0] log_icnt_b  [0:255];
    int n_dist_a, n_done_a, n_done_b, n_met_b;

    replica_sequencer u_dut_a (
        .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .stop(stop),
        .opt_mode(opt_mode), .iter_num(iter_num), .busy(busy_a), .done(done_a),
        .iter_count(icnt_a), .random_init(rinit_a), .random_run(rrun_a),
        .opt_command(opt_a), .c_distance(dist_a), .c_metropolis(met_a),
        .c_exchange(exc_a), .rbank(rbank_a)
    );

    replica_sequencer #(.EXCH_INTERVAL(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .stop(stop),
        .opt_mode(opt_mode), .iter_num(iter_num), .busy(busy_b), .done(done_b),
        .iter_count(icnt_b), .random_init(rinit_b), .random_run(rrun_b),
        .opt_command(opt_b), .c_distance(dist_b), .c_metropolis(met_b),
        .c_exchange(exc_b), .rbank(rbank_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Abort guard against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic seed, input logic [1:0] mode, input logic [31:0] n);
        seed_load = seed;
        opt_mode  = mode;
        iter_num  = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    // Record outputs for cycles 1..n; stop is pulsed in cycle stop_cyc.
    task automatic run_log(input int n, input int stop_cyc);
        for (int i = 0; i < 256; i++) begin
            log_opt_a[i] = 2'd0;   log_dist_a[i] = 1'b0;  log_met_a[i] = 2'd0;
            log_rbank_a[i] = 1'b0; log_busy_a[i] = 1'b0;  log_done_a[i] = 1'b0;
            log_rinit_a[i] = 1'b0; log_rrun_a[i] = 1'b0;  log_icnt_a[i] = 32'd0;
            log_met_b[i] = 2'd0;   log_exc_b[i] = 2'd0;   log_done_b[i] = 1'b0;
            log_icnt_b[i] = 32'd0;
        end
        n_dist_a = 0; n_done_a = 0; n_done_b = 0; n_met_b = 0;
        for (int c = 1; c <= n; c++) begin
            stop = (c == stop_cyc);
            log_opt_a[c]   = opt_a;
            log_dist_a[c]  = dist_a;
            log_met_a[c]   = met_a;
            log_rbank_a[c] = rbank_a;
            log_busy_a[c]  = busy_a;
            log_done_a[c]  = done_a;
            log_rinit_a[c] = rinit_a;
            log_rrun_a[c]  = rrun_a;
            log_icnt_a[c]  = icnt_a;
            log_met_b[c]   = met_b;
            log_exc_b[c]   = exc_b;
            log_done_b[c]  = done_b;
            log_icnt_b[c]  = icnt_b;
            if (dist_a == DIS_RUN) n_dist_a++;
            if (done_a) n_done_a++;
            if (done_b) n_done_b++;
            if (met_b != EXC_NOP) n_met_b++;
            tick();
        end
        stop = 1'b0;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        reset = 1'b0; start = 1'b0; seed_load = 1'b0; stop = 1'b0;
        opt_mode = 2'd0; iter_num = 32'd0;
        repeat (3) tick();

        // Reset state.
        check_val("rst_outs_a", 32'({opt_a, dist_a, met_a, exc_a, rbank_a, rinit_a, rrun_a, done_a, busy_a}), 32'd0);
        check_val("rst_outs_b", 32'({opt_b, dist_b, met_b, exc_b, rbank_b, rinit_b, rrun_b, done_b, busy_b}), 32'd0);
        check_val("rst_icnt_a", icnt_a, 32'd0);
        check_val("rst_icnt_b", icnt_b, 32'd0);
        reset = 1'b1;
        tick();

        // iter_num = 0 goes straight to FIN.
        start_run(1'b0, 2'd0, 32'd0);
        run_log(5, 0);
        check_val("zero_done", 32'(log_done_a[1]), 32'd1);
        check_val("zero_busy", 32'(log_busy_a[1]), 32'd0);
        check_val("zero_ndone", 32'(n_done_a), 32'd1);

        // Plain run, three iterations, alternating move types.
        start_run(1'b0, 2'd0, 32'd3);
        run_log(75, 0);
        check_val("plain_rrun1", 32'(log_rrun_a[1]), 32'd1);
        check_val("plain_ndist", 32'(n_dist_a), 32'd3);
        check_val("plain_dist2", 32'(log_dist_a[2]), 32'd1);
        check_val("plain_dist22", 32'(log_dist_a[22]), 32'd1);
        check_val("plain_dist42", 32'(log_dist_a[42]), 32'd1);
        check_val("plain_met11", 32'(log_met_a[11]), 32'(EXC_OPT));
        check_val("plain_rbank20", 32'(log_rbank_a[20]), 32'd0);
        check_val("plain_rbank21", 32'(log_rbank_a[21]), 32'd1);
        check_val("plain_rbank41", 32'(log_rbank_a[41]), 32'd0);
        check_val("plain_rbank61", 32'(log_rbank_a[61]), 32'd1);
        check_val("plain_icnt20", log_icnt_a[20], 32'd0);
        check_val("plain_icnt21", log_icnt_a[21], 32'd1);
        check_val("plain_opt1", 32'(log_opt_a[1]), 32'(OPT_OR));
        check_val("plain_opt21", 32'(log_opt_a[21]), 32'(OPT_TWO));
        check_val("plain_opt41", 32'(log_opt_a[41]), 32'(OPT_OR));
        check_val("plain_opt60", 32'(log_opt_a[60]), 32'(OPT_OR));
        check_val("plain_busy60", 32'(log_busy_a[60]), 32'd1);
        check_val("plain_done61", 32'(log_done_a[61]), 32'd1);
        check_val("plain_busy61", 32'(log_busy_a[61]), 32'd0);
        check_val("plain_ndone", 32'(n_done_a), 32'd1);
        check_val("plain_icnt61", log_icnt_a[61], 32'd3);

        // Exchanges every 2 iterations on instance B, 2-opt only.
        start_run(1'b0, 2'd2, 32'd4);
        run_log(105, 0);
        check_val("xch_opt21", 32'(log_opt_a[21]), 32'(OPT_TWO));
        check_val("xch_doneA81", 32'(log_done_a[81]), 32'd1);
        check_val("xch_met11", 32'(log_met_b[11]), 32'(EXC_OPT));
        check_val("xch_met41", 32'(log_met_b[41]), 32'(EXC_EVEN));
        check_val("xch_exc46", 32'(log_exc_b[46]), 32'(EXC_EVEN));
        check_val("xch_met91", 32'(log_met_b[91]), 32'(EXC_ODD));
        check_val("xch_exc96", 32'(log_exc_b[96]), 32'(EXC_ODD));
        check_val("xch_nmet", 32'(n_met_b), 32'd6);
        check_val("xch_done101", 32'(log_done_b[101]), 32'd1);
        check_val("xch_icnt101", log_icnt_b[101], 32'd4);

        // Seeded start, or-opt only, single iteration.
        start_run(1'b1, 2'd1, 32'd1);
        run_log(25, 0);
        check_val("seed_rinit1", 32'(log_rinit_a[1]), 32'd1);
        check_val("seed_rrun1", 32'(log_rrun_a[1]), 32'd0);
        check_val("seed_rrun2", 32'(log_rrun_a[2]), 32'd1);
        check_val("seed_opt2", 32'(log_opt_a[2]), 32'(OPT_OR));
        check_val("seed_done22", 32'(log_done_a[22]), 32'd1);

        // Early stop pulsed in DIST of iteration 2; B still performs its due exchange.
        start_run(1'b0, 2'd0, 32'd10);
        run_log(60, 25);
        check_val("stop_done41", 32'(log_done_a[41]), 32'd1);
        check_val("stop_icnt41", log_icnt_a[41], 32'd2);
        check_val("stop_ndoneA", 32'(n_done_a), 32'd1);
        check_val("stop_met41B", 32'(log_met_b[41]), 32'(EXC_EVEN));
        check_val("stop_done51B", 32'(log_done_b[51]), 32'd1);
        check_val("stop_ndoneB", 32'(n_done_b), 32'd1);
        check_val("stop_icnt51B", log_icnt_b[51], 32'd2);

        // Reset asserted in METRO of iteration 2.
        start_run(1'b0, 2'd0, 32'd3);
        run_log(31, 0);
        check_val("mrst_busy_pre", 32'(busy_a), 32'd1);
        check_val("mrst_icnt_pre", icnt_a, 32'd1);
        reset = 1'b0;
        #1;
        check_val("mrst_outs", 32'({opt_a, dist_a, met_a, exc_a, rbank_a, rinit_a, rrun_a, done_a, busy_a}), 32'd0);
        check_val("mrst_icnt", icnt_a, 32'd0);
        run_log(5, 0);
        check_val("mrst_ndone", 32'(n_done_a), 32'd0);
        reset = 1'b1;
        tick();
        start_run(1'b0, 2'd0, 32'd2);
        run_log(45, 0);
        check_val("mrst_ndist", 32'(n_dist_a), 32'd2);
        check_val("mrst_done41", 32'(log_done_a[41]), 32'd1);
        check_val("mrst_icnt41", log_icnt_a[41], 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
